mem_wb_retire: RTL and testbench

MEM/WB pipeline register and retire qualifier for the WISC pipelined core. Captures each instruction leaving the MEM stage, selects the write-back data, and presents one-shot retire strobes (RegWrite, MemRead, MemWrite, Halt) to the register file and the trace/stats monitor. It also maintains a sticky halted flag and a retired-instruction counter.

---
 rtl/wisc_pkg.sv | 26 ++
 rtl/mem_wb_retire_if.sv | 57 +++++
 rtl/mem_wb_retire.sv | 100 ++++++++++
 tb/tb_mem_wb_retire.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/wisc_pkg.sv
// Shared WISC core definitions: datapath widths and the retire record
// that the MEM/WB register and the trace monitor both consume.
package wisc_pkg;

   localparam int unsigned ARCH_WIDTH = 16;
   localparam int unsigned REG_WIDTH  = 4;
   localparam int unsigned CNT_WIDTH  = 32;

   // One retired instruction as seen by the register file and the monitor.
   // Strobe fields (reg_write, mem_read, mem_write, halt) are one-shot.
   typedef struct packed {
      logic                  valid;
      logic [ARCH_WIDTH-1:0] pc;
      logic [ARCH_WIDTH-1:0] inst;
      logic                  reg_write;
      logic [REG_WIDTH-1:0]  write_reg;
      logic [ARCH_WIDTH-1:0] write_data;
      logic                  mem_read;
      logic                  mem_write;
      logic [ARCH_WIDTH-1:0] addr;
      logic [ARCH_WIDTH-1:0] data_in;
      logic [ARCH_WIDTH-1:0] data_out;
      logic                  halt;
   } retire_rec_t;

endpackage

// File: rtl/mem_wb_retire_if.sv
// MEM->WB bus: MEM-stage instruction fields and pipeline controls in,
// retire record, sticky halt and retire counter out.
interface mem_wb_if #(
   parameter int unsigned ARCH_WIDTH = wisc_pkg::ARCH_WIDTH,
   parameter int unsigned REG_WIDTH  = wisc_pkg::REG_WIDTH,
   parameter int unsigned CNT_WIDTH  = wisc_pkg::CNT_WIDTH
);
   logic                  stall;
   logic                  flush;
   logic                  mem_valid;
   logic [ARCH_WIDTH-1:0] mem_pc;
   logic [ARCH_WIDTH-1:0] mem_inst;
   logic                  mem_reg_write;
   logic [REG_WIDTH-1:0]  mem_write_reg;
   logic [ARCH_WIDTH-1:0] mem_alu_result;
   logic                  mem_mem_to_reg;
   logic                  mem_mem_read;
   logic                  mem_mem_write;
   logic [ARCH_WIDTH-1:0] mem_store_data;
   logic [ARCH_WIDTH-1:0] mem_load_data;
   logic                  mem_halt;

   logic                  wb_valid;
   logic [ARCH_WIDTH-1:0] wb_pc;
   logic [ARCH_WIDTH-1:0] wb_inst;
   logic                  wb_reg_write;
   logic [REG_WIDTH-1:0]  wb_write_reg;
   logic [ARCH_WIDTH-1:0] wb_write_data;
   logic                  wb_mem_read;
   logic                  wb_mem_write;
   logic [ARCH_WIDTH-1:0] wb_mem_addr;
   logic [ARCH_WIDTH-1:0] wb_mem_data_in;
   logic [ARCH_WIDTH-1:0] wb_mem_data_out;
   logic                  wb_halt;
   logic                  halted;
   logic [CNT_WIDTH-1:0]  retire_count;

   // Pipeline side driving the MEM fields
   modport master (
      output stall, flush, mem_valid, mem_pc, mem_inst, mem_reg_write,
             mem_write_reg, mem_alu_result, mem_mem_to_reg, mem_mem_read,
             mem_mem_write, mem_store_data, mem_load_data, mem_halt,
      input  wb_valid, wb_pc, wb_inst, wb_reg_write, wb_write_reg,
             wb_write_data, wb_mem_read, wb_mem_write, wb_mem_addr,
             wb_mem_data_in, wb_mem_data_out, wb_halt, halted, retire_count
   );

   // MEM/WB register side
   modport slave (
      input  stall, flush, mem_valid, mem_pc, mem_inst, mem_reg_write,
             mem_write_reg, mem_alu_result, mem_mem_to_reg, mem_mem_read,
             mem_mem_write, mem_store_data, mem_load_data, mem_halt,
      output wb_valid, wb_pc, wb_inst, wb_reg_write, wb_write_reg,
             wb_write_data, wb_mem_read, wb_mem_write, wb_mem_addr,
             wb_mem_data_in, wb_mem_data_out, wb_halt, halted, retire_count
   );
endinterface

// File: rtl/mem_wb_retire.sv
// MEM/WB pipeline register with one-shot retire strobes, sticky halted
// flag and a saturating retired-instruction counter.
module mem_wb_retire #(
   parameter int unsigned ARCH_WIDTH = wisc_pkg::ARCH_WIDTH,
   parameter int unsigned REG_WIDTH  = wisc_pkg::REG_WIDTH,
   parameter int unsigned CNT_WIDTH  = wisc_pkg::CNT_WIDTH
) (
   input  logic    clk,
   input  logic    rst,
   mem_wb_if.slave bus
);
   import wisc_pkg::*;

   // The record layout is shared with the monitor, so widths are pinned.
   if (ARCH_WIDTH != wisc_pkg::ARCH_WIDTH || REG_WIDTH != wisc_pkg::REG_WIDTH) begin : g_width_chk
      $error("mem_wb_retire: ARCH_WIDTH/REG_WIDTH must match wisc_pkg");
   end

   retire_rec_t           rec_q, rec_d, mem_rec_c;
   logic                  fresh_q, fresh_d;
   logic                  halted_q, halted_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic                  bubble_c;

   // Build the record for the incoming MEM instruction (R0 writes dropped)
   always_comb begin
      mem_rec_c            = '0;
      mem_rec_c.valid      = 1'b1;
      mem_rec_c.pc         = bus.mem_pc;
      mem_rec_c.inst       = bus.mem_inst;
      mem_rec_c.reg_write  = bus.mem_reg_write & (bus.mem_write_reg != '0);
      mem_rec_c.write_reg  = bus.mem_write_reg;
      mem_rec_c.write_data = bus.mem_mem_to_reg ? bus.mem_load_data : bus.mem_alu_result;
      mem_rec_c.mem_read   = bus.mem_mem_read;
      mem_rec_c.mem_write  = bus.mem_mem_write;
      mem_rec_c.addr       = bus.mem_alu_result;
      mem_rec_c.data_in    = bus.mem_store_data;
      mem_rec_c.data_out   = bus.mem_load_data;
      mem_rec_c.halt       = bus.mem_halt;
   end

   // Next-state: hold on stall (retiring strobes), bubble, or load; a halt
   // retiring this cycle already blocks the instruction behind it.
   always_comb begin
      rec_d    = rec_q;
      fresh_d  = fresh_q;
      halted_d = halted_q | rec_q.halt;
      cnt_d    = cnt_q;
      bubble_c = bus.flush | halted_q | rec_q.halt | ~bus.mem_valid;

      if (rec_q.valid && fresh_q && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_WIDTH'(1);
      end

      if (bus.stall) begin
         fresh_d         = 1'b0;
         rec_d.reg_write = 1'b0;
         rec_d.mem_read  = 1'b0;
         rec_d.mem_write = 1'b0;
         rec_d.halt      = 1'b0;
      end else if (bubble_c) begin
         rec_d   = '0;
         fresh_d = 1'b0;
      end else begin
         rec_d   = mem_rec_c;
         fresh_d = 1'b1;
      end
   end

   // State register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         rec_q    <= '0;
         fresh_q  <= 1'b0;
         halted_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         rec_q    <= rec_d;
         fresh_q  <= fresh_d;
         halted_q <= halted_d;
         cnt_q    <= cnt_d;
      end
   end

   assign bus.wb_valid        = rec_q.valid;
   assign bus.wb_pc           = rec_q.pc;
   assign bus.wb_inst         = rec_q.inst;
   assign bus.wb_reg_write    = rec_q.reg_write;
   assign bus.wb_write_reg    = rec_q.write_reg;
   assign bus.wb_write_data   = rec_q.write_data;
   assign bus.wb_mem_read     = rec_q.mem_read;
   assign bus.wb_mem_write    = rec_q.mem_write;
   assign bus.wb_mem_addr     = rec_q.addr;
   assign bus.wb_mem_data_in  = rec_q.data_in;
   assign bus.wb_mem_data_out = rec_q.data_out;
   assign bus.wb_halt         = rec_q.halt;
   assign bus.halted          = halted_q;
   assign bus.retire_count    = cnt_q;

endmodule

// File: tb/tb_mem_wb_retire.sv
// Bench for mem_wb_retire: directed test-plan sequences plus random
// traffic checked every cycle against a behavioural retire model; a
// second 4-bit-counter instance covers counter saturation.
module tb_mem_wb_retire;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic rst2 = 1'b0;

   mem_wb_if #(.ARCH_WIDTH(16), .REG_WIDTH(4), .CNT_WIDTH(32)) bus ();
   mem_wb_if #(.ARCH_WIDTH(16), .REG_WIDTH(4), .CNT_WIDTH(4))  bus2 ();

   mem_wb_retire #(.ARCH_WIDTH(16), .REG_WIDTH(4), .CNT_WIDTH(32)) dut (
      .clk (clk), .rst (rst), .bus (bus));

   mem_wb_retire #(.ARCH_WIDTH(16), .REG_WIDTH(4), .CNT_WIDTH(4)) dut2 (
      .clk (clk), .rst (rst2), .bus (bus2));

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Model of what WB must show: the last captured instruction, whether it
   // was just captured (strobes visible), halted state and retire total.
   logic        m_valid, m_new, m_halted;
   logic [15:0] m_pc, m_inst, m_wdata, m_addr, m_din, m_dout;
   logic        m_rw, m_mr, m_mw, m_halt;
   logic [3:0]  m_wreg;
   longint      m_cnt;
   logic        m2_valid;
   longint      m2_cnt;

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_valid = 0; m_new = 0; m_pc = 0; m_inst = 0; m_rw = 0; m_wreg = 0;
      m_wdata = 0; m_mr = 0; m_mw = 0; m_addr = 0; m_din = 0; m_dout = 0;
      m_halt = 0;
   endtask

   // Apply one clock edge of the retire rules to the model
   task automatic model_edge();
      logic retiring, halt_now;
      if (!rst) begin
         model_clear();
         m_halted = 0;
         m_cnt    = 0;
      end else begin
         retiring = m_valid && m_new;
         halt_now = m_new && m_halt;
         if (retiring) m_cnt = (m_cnt < 64'hFFFF_FFFF) ? m_cnt + 1 : m_cnt;
         if (bus.stall) begin
            m_new = 0;
         end else if (bus.flush || m_halted || halt_now || !bus.mem_valid) begin
            model_clear();
         end else begin
            m_valid = 1;
            m_new   = 1;
            m_pc    = bus.mem_pc;
            m_inst  = bus.mem_inst;
            m_rw    = bus.mem_reg_write && (bus.mem_write_reg != 0);
            m_wreg  = bus.mem_write_reg;
            m_wdata = bus.mem_mem_to_reg ? bus.mem_load_data : bus.mem_alu_result;
            m_mr    = bus.mem_mem_read;
            m_mw    = bus.mem_mem_write;
            m_addr  = bus.mem_alu_result;
            m_din   = bus.mem_store_data;
            m_dout  = bus.mem_load_data;
            m_halt  = bus.mem_halt;
         end
         if (halt_now) m_halted = 1;
      end
      // Saturating instance: retires every cycle once out of reset
      if (!rst2) begin
         m2_valid = 0;
         m2_cnt   = 0;
      end else begin
         if (m2_valid) m2_cnt = (m2_cnt < 15) ? m2_cnt + 1 : 15;
         m2_valid = 1;
      end
   endtask

   task automatic compare();
      chk("wb_valid",        bus.wb_valid,        m_valid);
      chk("wb_pc",           bus.wb_pc,           m_pc);
      chk("wb_inst",         bus.wb_inst,         m_inst);
      chk("wb_reg_write",    bus.wb_reg_write,    m_rw && m_new);
      chk("wb_write_reg",    bus.wb_write_reg,    m_wreg);
      chk("wb_write_data",   bus.wb_write_data,   m_wdata);
      chk("wb_mem_read",     bus.wb_mem_read,     m_mr && m_new);
      chk("wb_mem_write",    bus.wb_mem_write,    m_mw && m_new);
      chk("wb_mem_addr",     bus.wb_mem_addr,     m_addr);
      chk("wb_mem_data_in",  bus.wb_mem_data_in,  m_din);
      chk("wb_mem_data_out", bus.wb_mem_data_out, m_dout);
      chk("wb_halt",         bus.wb_halt,         m_halt && m_new);
      chk("halted",          bus.halted,          m_halted);
      chk("retire_count",    bus.retire_count,    m_cnt);
      chk("sat_count",       bus2.retire_count,   m2_cnt);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare();
   endtask

   task automatic set_inst(input logic v, input logic [15:0] pc, input logic [15:0] inst,
                           input logic rw, input logic [3:0] wreg, input logic [15:0] alu,
                           input logic mtr, input logic mr, input logic mw,
                           input logic [15:0] sd, input logic [15:0] ld, input logic hlt);
      bus.mem_valid = v;       bus.mem_pc = pc;          bus.mem_inst = inst;
      bus.mem_reg_write = rw;  bus.mem_write_reg = wreg; bus.mem_alu_result = alu;
      bus.mem_mem_to_reg = mtr; bus.mem_mem_read = mr;   bus.mem_mem_write = mw;
      bus.mem_store_data = sd; bus.mem_load_data = ld;   bus.mem_halt = hlt;
   endtask

   task automatic set_idle();
      set_inst(0, 16'h0, 16'h0, 0, 4'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0, 0);
   endtask

   initial begin
      model_clear();
      m_halted = 0; m_cnt = 0; m2_valid = 0; m2_cnt = 0;
      bus.stall = 0; bus.flush = 0;
      set_idle();
      bus2.stall = 0; bus2.flush = 0; bus2.mem_valid = 1; bus2.mem_pc = 16'h0;
      bus2.mem_inst = 16'h0; bus2.mem_reg_write = 1; bus2.mem_write_reg = 4'h1;
      bus2.mem_alu_result = 16'h0; bus2.mem_mem_to_reg = 0; bus2.mem_mem_read = 0;
      bus2.mem_mem_write = 0; bus2.mem_store_data = 16'h0; bus2.mem_load_data = 16'h0;
      bus2.mem_halt = 0;

      // Reset state
      step(); step();
      chk("rst_valid", bus.wb_valid, 0);
      chk("rst_count", bus.retire_count, 0);
      chk("rst_halted", bus.halted, 0);
      rst = 1; rst2 = 1;

      // ADD R3 <- 0x0042
      set_inst(1, 16'h0010, 16'h1342, 1, 4'd3, 16'h0042, 0, 0, 0, 16'h0, 16'h0, 0);
      step();
      chk("add_rw", bus.wb_reg_write, 1);
      chk("add_reg", bus.wb_write_reg, 3);
      chk("add_data", bus.wb_write_data, 16'h0042);
      set_idle();
      step();
      chk("add_count", bus.retire_count, 1);

      // LW from 0x0010 returning 0xBEEF, then a 3-cycle stall
      set_inst(1, 16'h0012, 16'h8510, 1, 4'd5, 16'h0010, 1, 1, 0, 16'h0, 16'hBEEF, 0);
      step();
      chk("lw_mr_first", bus.wb_mem_read, 1);
      chk("lw_data", bus.wb_write_data, 16'hBEEF);
      chk("lw_addr", bus.wb_mem_addr, 16'h0010);
      bus.stall = 1;
      set_idle();
      for (int i = 0; i < 3; i++) begin
         step();
         chk("lw_mr_stall", bus.wb_mem_read, 0);
         chk("lw_data_held", bus.wb_write_data, 16'hBEEF);
      end
      chk("lw_count", bus.retire_count, 2);
      bus.stall = 0;

      // Write to R0 is not a register write but still retires
      set_inst(1, 16'h0014, 16'h1034, 1, 4'd0, 16'h1234, 0, 0, 0, 16'h0, 16'h0, 0);
      step();
      chk("r0_rw", bus.wb_reg_write, 0);
      chk("r0_valid", bus.wb_valid, 1);
      set_idle();
      step();
      chk("r0_count", bus.retire_count, 3);

      // stall+flush holds; flush alone then bubbles
      set_inst(1, 16'h0016, 16'h1455, 1, 4'd4, 16'h0055, 0, 0, 0, 16'h0, 16'h0, 0);
      step();
      set_inst(1, 16'h0018, 16'h1777, 1, 4'd7, 16'h0077, 0, 0, 0, 16'h0, 16'h0, 0);
      bus.stall = 1; bus.flush = 1;
      step();
      chk("sf_valid", bus.wb_valid, 1);
      chk("sf_data", bus.wb_write_data, 16'h0055);
      bus.stall = 0;
      step();
      chk("f_valid", bus.wb_valid, 0);
      bus.flush = 0;

      // HLT followed by two SW: halt once, then silence
      set_inst(1, 16'h0020, 16'hF000, 0, 4'd0, 16'h0, 0, 0, 0, 16'h0, 16'h0, 1);
      step();
      chk("hlt_pulse", bus.wb_halt, 1);
      chk("hlt_not_yet", bus.halted, 0);
      set_inst(1, 16'h0022, 16'h9120, 0, 4'd0, 16'h0030, 0, 0, 1, 16'hAAAA, 16'h0, 0);
      step();
      chk("hlt_halted", bus.halted, 1);
      chk("hlt_once", bus.wb_halt, 0);
      chk("hlt_no_sw1", bus.wb_mem_write, 0);
      set_inst(1, 16'h0024, 16'h9120, 0, 4'd0, 16'h0032, 0, 0, 1, 16'hBBBB, 16'h0, 0);
      step();
      chk("hlt_no_sw2", bus.wb_mem_write, 0);
      rst = 0;
      step();
      chk("rst_clr_halted", bus.halted, 0);
      chk("rst_clr_count", bus.retire_count, 0);
      rst = 1;

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         rst       = ($urandom_range(0, 149) != 0);
         bus.stall = ($urandom_range(0, 3) == 0);
         bus.flush = ($urandom_range(0, 7) == 0);
         set_inst(($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
                  1'($urandom), 4'($urandom_range(0, 15)), 16'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom),
                  16'($urandom), 16'($urandom), ($urandom_range(0, 59) == 0));
         step();
      end

      chk("sat_final", bus2.retire_count, 15);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
